fir_ctrl_multich: RTL and testbench
===================================

// Module: fir_ctrl_multich
// PURPOSE
//  Parametrised, multi-channel successor to the single-channel 64-tap FIR sequencer.
//  - Accepts one input sample per transaction (valid/ready), tagged with a channel ID.
//  - Sequences the coefficient-ROM address and MAC enables over TAPS cycles.
//  - Waits out the MAC pipeline latency, then presents the result with valid/ready backpressure.
//  - Sits between the sample source and the per-channel shift-register/MAC datapath.
// PARAMETERS
//  TAPS      64  filter length, >=2; sets EXEC length and address range
//  CHANNELS  2   number of independent channels, >=1
//  MAC_LAT   2   MAC pipeline depth in cycles, >=0; DRAIN length
//  ADDR_W    $clog2(TAPS)             coefficient address width (derived)
//  CH_W      max(1,$clog2(CHANNELS))  channel ID width (derived)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous active-low reset (0 = reset at clk edge)
//  inputValid   in   1       sample available
//  inputChannel in   CH_W    channel ID of offered sample
//  inputReady   out  1       controller accepts sample this cycle
//  shift        out  1       shift sample into shiftChannel's delay line
//  shiftChannel out  CH_W    channel selected for shift/MAC/output
//  flush        out  1       clear accumulator
//  macEn        out  1       accumulate coeff[address]*tap[address]
//  address      out  ADDR_W  coefficient/tap index
//  outputValid  out  1       accumulator result valid
//  outputReady  in   1       downstream accepts result
//  outputChannel out CH_W    channel of presented result
//  busy         out  1       high in any state except IDLE
//  chanErr      out  1       1-cycle pulse: offered sample had inputChannel>=CHANNELS
// BEHAVIOUR
//  Reset and output decode
//  - rst==0 at an edge: state<=IDLE, counters<=0, chReg<=0.
//  - All outputs are Moore-decoded from state/counters, except inputReady and chanErr.
//  - While rst==0, every output is 0, including inputReady.
//  States: IDLE, INIT, EXEC, DRAIN, OUTPUT
//  - IDLE: inputReady=1.
//    - Handshake = inputValid&inputReady.
//    - Valid ID: chReg<=inputChannel, go INIT.
//    - Invalid ID: sample consumed, chanErr=1 that cycle, stay IDLE.
//  - INIT (1 cycle): flush=1, shift=1, address=0, go EXEC.
//  - EXEC (TAPS cycles): macEn=1, address=0,1,...,TAPS-1 (one step per cycle).
//    - address==TAPS-1: go DRAIN if MAC_LAT>0, else OUTPUT.
//    - address never wraps inside EXEC; it is 0 in every other state.
//  - DRAIN (MAC_LAT cycles): macEn=0, then go OUTPUT.
//  - OUTPUT: outputValid=1, outputChannel=chReg; hold until outputReady.
//    - outputValid must not drop, and outputChannel must not change, before acceptance.
//    - On outputReady, inputReady=1 (back-to-back):
//      - Simultaneous valid sample: accept it, chReg<=inputChannel, go INIT (no IDLE bubble).
//      - Otherwise go IDLE.
//  - shiftChannel=chReg in all states.
//  - inputReady=0 in INIT/EXEC/DRAIN, and in OUTPUT while outputReady==0.
//  Latency and throughput
//  - Handshake at cycle 0: INIT at 1, EXEC at 2..TAPS+1, outputValid first at TAPS+2+MAC_LAT.
//  - Sustained throughput with outputReady=1: one sample per TAPS+2+MAC_LAT cycles.
//  Boundaries
//  - Reset mid-EXEC/DRAIN/OUTPUT: the pending result is discarded; no outputValid after reset.
//  - inputValid while busy: ignored, not lost; the source holds it until inputReady.
// TESTING
//  1. TAPS=64,MAC_LAT=2: valid ch1 at cyc0 -> flush&shift at cyc1; address 0..63 at cyc2..65;
//     outputValid, outputChannel=1 at cyc68.
//  2. outputReady held 0 for 10 cycles in OUTPUT -> outputValid stays 1, inputReady=0,
//     address=0; accepted at cyc 78.
//  3. Back-to-back: outputReady=1 with inputValid ch0 in OUTPUT -> INIT next cycle,
//     outputChannel of the next result=0.
//  4. inputChannel=3 with CHANNELS=2 -> chanErr pulse, busy stays 0, no flush/shift.
//  5. rst=0 at address=30 -> next cycle IDLE, outputs 0; after release, inputReady=1.
//  6. TAPS=5,MAC_LAT=0: EXEC -> OUTPUT directly; outputValid at cyc7.

Source files
------------

// File: rtl/fir_ctrl_multich.sv
// Multi-channel FIR sequencer: accepts a channel-tagged sample, walks the coefficient address
// over TAPS cycles, waits out the MAC pipeline, then presents the result with backpressure.
module fir_ctrl_multich #(
    parameter int unsigned TAPS     = 64,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned MAC_LAT  = 2,
    localparam int unsigned ADDR_W  = $clog2(TAPS),
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inputValid,
    input  logic [CH_W-1:0]   inputChannel,
    output logic              inputReady,
    output logic              shift,
    output logic [CH_W-1:0]   shiftChannel,
    output logic              flush,
    output logic              macEn,
    output logic [ADDR_W-1:0] address,
    output logic              outputValid,
    input  logic              outputReady,
    output logic [CH_W-1:0]   outputChannel,
    output logic              busy,
    output logic              chanErr
);

    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        EXEC,
        DRAIN,
        OUTPUT
    } state_t;

    state_t             state, stateNext;
    logic [ADDR_W-1:0]  addrCnt, addrCntNext;
    logic [DRAIN_W-1:0] drainCnt, drainCntNext;
    logic [CH_W-1:0]    chReg, chRegNext;
    logic               chanOk;

    assign chanOk = 32'(inputChannel) < CHANNELS;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            addrCnt  <= '0;
            drainCnt <= '0;
            chReg    <= '0;
        end else begin
            state    <= stateNext;
            addrCnt  <= addrCntNext;
            drainCnt <= drainCntNext;
            chReg    <= chRegNext;
        end
    end

    always_comb begin
        stateNext     = state;
        addrCntNext   = addrCnt;
        drainCntNext  = drainCnt;
        chRegNext     = chReg;
        inputReady    = 1'b0;
        shift         = 1'b0;
        flush         = 1'b0;
        macEn         = 1'b0;
        address       = '0;
        outputValid   = 1'b0;
        outputChannel = '0;
        busy          = 1'b1;
        chanErr       = 1'b0;
        shiftChannel  = chReg;

        case (state)
            IDLE: begin
                busy       = 1'b0;
                inputReady = 1'b1;
            end
            INIT: begin
                flush       = 1'b1;
                shift       = 1'b1;
                addrCntNext = '0;
                stateNext   = EXEC;
            end
            EXEC: begin
                macEn   = 1'b1;
                address = addrCnt;
                if (addrCnt == ADDR_W'(TAPS - 1)) begin
                    addrCntNext  = '0;
                    drainCntNext = '0;
                    stateNext    = (MAC_LAT > 0) ? DRAIN : OUTPUT;
                end else begin
                    addrCntNext = addrCnt + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drainCnt == DRAIN_W'(MAC_LAT - 1)) begin
                    drainCntNext = '0;
                    stateNext    = OUTPUT;
                end else begin
                    drainCntNext = drainCnt + DRAIN_W'(1);
                end
            end
            OUTPUT: begin
                outputValid   = 1'b1;
                outputChannel = chReg;
                inputReady    = outputReady;
                if (outputReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // A sample accepted on the same cycle as a result skips the IDLE bubble.
        if (inputValid && inputReady) begin
            if (chanOk) begin
                chRegNext = inputChannel;
                stateNext = INIT;
            end else begin
                chanErr = 1'b1;
            end
        end

        if (!rst) begin
            inputReady    = 1'b0;
            shift         = 1'b0;
            shiftChannel  = '0;
            flush         = 1'b0;
            macEn         = 1'b0;
            address       = '0;
            outputValid   = 1'b0;
            outputChannel = '0;
            busy          = 1'b0;
            chanErr       = 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_ctrl_multich.sv
// Bench for fir_ctrl_multich: a 64-tap/2-channel/2-latency instance (A) and a
// 5-tap/3-channel/0-latency instance (B), with a channel scoreboard on each.
module tb_fir_ctrl_multich;

    localparam int unsigned A_TAPS = 64;
    localparam int unsigned A_CH   = 2;
    localparam int unsigned A_LAT  = 2;
    localparam int unsigned B_TAPS = 5;
    localparam int unsigned B_CH   = 3;
    localparam int unsigned B_LAT  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;

    logic       rA, vA, orA, rdyA, shA, flA, macA, ovA, busyA, errA;
    logic [0:0] chA, shChA, oChA;
    logic [5:0] addrA;

    logic       rB, vB, orB, rdyB, shB, flB, macB, ovB, busyB, errB;
    logic [1:0] chB, shChB, oChB;
    logic [2:0] addrB;

    fir_ctrl_multich #(.TAPS(A_TAPS), .CHANNELS(A_CH), .MAC_LAT(A_LAT)) dutA (
        .clk(clk), .rst(rA), .inputValid(vA), .inputChannel(chA), .inputReady(rdyA),
        .shift(shA), .shiftChannel(shChA), .flush(flA), .macEn(macA), .address(addrA),
        .outputValid(ovA), .outputReady(orA), .outputChannel(oChA), .busy(busyA),
        .chanErr(errA)
    );

    fir_ctrl_multich #(.TAPS(B_TAPS), .CHANNELS(B_CH), .MAC_LAT(B_LAT)) dutB (
        .clk(clk), .rst(rB), .inputValid(vB), .inputChannel(chB), .inputReady(rdyB),
        .shift(shB), .shiftChannel(shChB), .flush(flB), .macEn(macB), .address(addrB),
        .outputValid(ovB), .outputReady(orB), .outputChannel(oChB), .busy(busyB),
        .chanErr(errB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: channel pushed on accepted valid sample, popped on accepted result.
    logic [0:0] qA[$];
    logic [1:0] qB[$];

    always @(negedge clk) begin
        if (!rA) begin
            qA.delete();
        end else begin
            if (ovA && orA) begin
                if (qA.size() == 0) check("sbA_spurious_output", 32'(ovA), 32'(0));
                else                check("sbA_channel", 32'(oChA), 32'(qA.pop_front()));
            end
            if (vA && rdyA && (32'(chA) < A_CH)) qA.push_back(chA);
        end
    end

    always @(negedge clk) begin
        if (!rB) begin
            qB.delete();
        end else begin
            if (ovB && orB) begin
                if (qB.size() == 0) check("sbB_spurious_output", 32'(ovB), 32'(0));
                else                check("sbB_channel", 32'(oChB), 32'(qB.pop_front()));
            end
            if (vB && rdyB && (32'(chB) < B_CH)) qB.push_back(chB);
        end
    end

    // Instance A helpers: packed {inputReady, shift, flush, macEn, address, outputValid, busy, chanErr}
    function automatic logic [31:0] pkA(int rdy, int sh, int fl, int mac, int addr, int ov,
                                        int bsy, int err);
        return 32'({1'(rdy), 1'(sh), 1'(fl), 1'(mac), 6'(addr), 1'(ov), 1'(bsy), 1'(err)});
    endfunction

    function automatic logic [31:0] actA();
        return 32'({rdyA, shA, flA, macA, addrA, ovA, busyA, errA});
    endfunction

    // Expected A word d cycles after a handshake, up to and including result acceptance.
    function automatic logic [31:0] expRunA(int d, int outR);
        if (d == 1)                            return pkA(0, 1, 1, 0, 0, 0, 1, 0);
        if (d <= int'(A_TAPS) + 1)             return pkA(0, 0, 0, 1, d - 2, 0, 1, 0);
        if (d < int'(A_TAPS + 2 + A_LAT))      return pkA(0, 0, 0, 0, 0, 0, 1, 0);
        return pkA(outR, 0, 0, 0, 0, 1, 1, 0);
    endfunction

    // Instance B cycle-by-cycle vector table.
    typedef struct {
        logic       rst, inV, outR;
        logic [1:0] inCh;
        logic       rdy, sh, fl, mac;
        logic [2:0] addr;
        logic       ov;
        logic [1:0] oCh, shCh;
        logic       bsy, err;
    } vecB_t;

    function automatic vecB_t mkB(int r, int v, int ch, int o, int rdy, int sh, int fl,
                                  int mac, int addr, int ov, int och, int sch, int bsy, int err);
        vecB_t t;
        t.rst  = 1'(r);   t.inV = 1'(v);   t.inCh = 2'(ch);  t.outR = 1'(o);
        t.rdy  = 1'(rdy); t.sh  = 1'(sh);  t.fl   = 1'(fl);  t.mac  = 1'(mac);
        t.addr = 3'(addr); t.ov = 1'(ov);  t.oCh  = 2'(och); t.shCh = 2'(sch);
        t.bsy  = 1'(bsy); t.err = 1'(err);
        return t;
    endfunction

    function automatic logic [31:0] expB(vecB_t t);
        return 32'({t.rdy, t.sh, t.fl, t.mac, t.addr, t.ov, t.oCh, t.shCh, t.bsy, t.err});
    endfunction

    function automatic logic [31:0] actB();
        return 32'({rdyB, shB, flB, macB, addrB, ovB, oChB, shChB, busyB, errB});
    endfunction

    vecB_t tbl[$];

    initial begin
        rA = 1'b0; vA = 1'b0; chA = '0; orA = 1'b0;
        rB = 1'b0; vB = 1'b0; chB = '0; orB = 1'b0;

        //           rst inV ch outR | rdy sh fl mac addr ov oCh shCh busy err
        tbl.push_back(mkB(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkB(1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkB(1, 1, 3, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkB(1, 1, 2, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkB(1, 1, 1, 0,   0, 1, 1, 0, 0, 0, 0, 2, 1, 0));
        for (int k = 0; k < int'(B_TAPS); k++)
            tbl.push_back(mkB(1, 1, 1, 0, 0, 0, 0, 1, k, 0, 0, 2, 1, 0));
        tbl.push_back(mkB(1, 1, 1, 0,   0, 0, 0, 0, 0, 1, 2, 2, 1, 0));
        tbl.push_back(mkB(1, 1, 1, 1,   1, 0, 0, 0, 0, 1, 2, 2, 1, 0));
        tbl.push_back(mkB(1, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0, 1, 1, 0));
        for (int k = 0; k < int'(B_TAPS); k++)
            tbl.push_back(mkB(1, 0, 0, 1, 0, 0, 0, 1, k, 0, 0, 1, 1, 0));
        tbl.push_back(mkB(1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mkB(1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rB = tbl[i].rst; vB = tbl[i].inV; chB = tbl[i].inCh; orB = tbl[i].outR;
            @(negedge clk);
            check($sformatf("B_vec%0d", i), actB(), expB(tbl[i]));
        end

        // Instance A: reset, then one sample on ch1 with a 10-cycle output stall
        @(posedge clk); #1;
        @(negedge clk);
        check("A_reset", actA(), pkA(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1; rA = 1'b1;
        @(negedge clk);
        check("A_idle", actA(), pkA(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1; vA = 1'b1; chA = 1'b1;
        @(negedge clk);
        check("A_accept_ch1", actA(), pkA(1, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 77; c++) begin
            @(posedge clk); #1;
            vA = (c >= 60); chA = 1'b0; orA = 1'b0;
            @(negedge clk);
            if (c <= 67) check($sformatf("A_run1_c%0d", c), actA(), expRunA(c, 0));
            else         check($sformatf("A_stall_c%0d", c), actA(), pkA(0, 0, 0, 0, 0, 1, 1, 0));
            if (c == 1)  check("A_shiftChannel_ch1", 32'(shChA), 32'(1));
            if (c == 68) check("A_outputChannel_ch1", 32'(oChA), 32'(1));
            if (c == 77) check("A_outputChannel_held", 32'(oChA), 32'(1));
        end
        @(posedge clk); #1; orA = 1'b1;
        @(negedge clk);
        check("A_accept_b2b_c78", actA(), pkA(1, 0, 0, 0, 0, 1, 1, 0));
        for (int d = 1; d <= 68; d++) begin
            @(posedge clk); #1; vA = 1'b0;
            @(negedge clk);
            check($sformatf("A_run2_d%0d", d), actA(), expRunA(d, 1));
            if (d == 1)  check("A_shiftChannel_ch0", 32'(shChA), 32'(0));
            if (d == 68) check("A_outputChannel_ch0", 32'(oChA), 32'(0));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("A_idle_after_b2b", actA(), pkA(1, 0, 0, 0, 0, 0, 0, 0));

        // Reset while address is 30: pending ch1 result must never appear
        @(posedge clk); #1; vA = 1'b1; chA = 1'b1;
        @(negedge clk);
        check("A_accept_ch1_again", actA(), pkA(1, 0, 0, 0, 0, 0, 0, 0));
        for (int d = 1; d <= 31; d++) begin
            @(posedge clk); #1; vA = 1'b0;
            @(negedge clk);
            check($sformatf("A_run3_d%0d", d), actA(), expRunA(d, 1));
        end
        for (int d = 32; d <= 33; d++) begin
            @(posedge clk); #1; rA = 1'b0;
            @(negedge clk);
            check($sformatf("A_in_reset_d%0d", d), actA(), pkA(0, 0, 0, 0, 0, 0, 0, 0));
            check($sformatf("A_in_reset_chans_d%0d", d), 32'({shChA, oChA}), 32'(0));
        end
        @(posedge clk); #1; rA = 1'b1;
        @(negedge clk);
        check("A_after_reset", actA(), pkA(1, 0, 0, 0, 0, 0, 0, 0));
        check("A_after_reset_chReg", 32'(shChA), 32'(0));
        for (int d = 0; d < 80; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("A_no_stale_output_%0d", d), actA(), pkA(1, 0, 0, 0, 0, 0, 0, 0));
        end

        check("sbA_pending", 32'(qA.size()), 32'(0));
        check("sbB_pending", 32'(qB.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
